// File: rtl/nnet_output_framer.sv
// rtl/nnet_output_framer.sv - re-frames the HLS result stream into tlast-delimited vectors of widened samples
module nnet_output_framer #(
    parameter int DIN_W       = 18,
    parameter int DOUT_W      = 32,
    parameter int SIGN_EXTEND = 1,
    parameter int FIFO_AWIDTH = 5
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   clear,
    input  logic [15:0]            nnet_size_out,
    input  logic [DIN_W-1:0]       res_tdata,
    input  logic                   res_tvalid,
    output logic                   res_tready,
    output logic [DOUT_W-1:0]      o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [FIFO_AWIDTH:0]   occupancy,
    output logic [31:0]            vec_count
);

    localparam int DEPTH = 1 << FIFO_AWIDTH;
    localparam int PW    = FIFO_AWIDTH + 1;

    logic [DOUT_W:0]       mem [DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         wptr_n;
    logic [PW-1:0]         rptr_n;
    logic [PW-1:0]         occ_n;
    logic                  rdy_q;
    logic                  vld_q;
    logic [DOUT_W:0]       head_q;
    logic [DOUT_W:0]       head_n;
    logic                  head_load;
    logic                  push;
    logic                  pop;
    logic [15:0]           cnt_q;
    logic [15:0]           len_q;
    logic [15:0]           cur_len;
    logic                  in_last;
    logic [DOUT_W-1:0]     in_word;
    logic [DOUT_W:0]       in_entry;

    generate
        if (DOUT_W == DIN_W) begin : g_same_width
            assign in_word = res_tdata;
        end else if (SIGN_EXTEND != 0) begin : g_sign_ext
            assign in_word = {{(DOUT_W-DIN_W){res_tdata[DIN_W-1]}}, res_tdata};
        end else begin : g_zero_ext
            assign in_word = {{(DOUT_W-DIN_W){1'b0}}, res_tdata};
        end
    endgenerate

    assign push       = res_tvalid & rdy_q;
    assign pop        = vld_q & o_tready;
    assign res_tready = rdy_q;
    assign o_tvalid   = vld_q;
    assign o_tdata    = head_q[DOUT_W-1:0];
    assign o_tlast    = head_q[DOUT_W];
    assign occupancy  = wptr_q - rptr_q;

    // A vector length of zero would never produce tlast, so it frames as single-sample vectors.
    always_comb begin
        cur_len = len_q;
        if (cnt_q == 16'd0) begin
            cur_len = (nnet_size_out == 16'd0) ? 16'd1 : nnet_size_out;
        end
    end

    assign in_last  = (cnt_q == cur_len - 16'd1);
    assign in_entry = {in_last, in_word};

    assign wptr_n = wptr_q + PW'(push);
    assign rptr_n = rptr_q + PW'(pop);
    assign occ_n  = wptr_n - rptr_n;

    // The head register refills when it is empty or being consumed; if the new head is the
    // entry being written this cycle, it is taken straight from the input.
    always_comb begin
        head_load = pop | ~vld_q;
        head_n    = mem[rptr_n[FIFO_AWIDTH-1:0]];
        if (push && (rptr_n == wptr_q)) begin
            head_n = in_entry;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push && !clear) begin
            mem[wptr_q[FIFO_AWIDTH-1:0]] <= in_entry;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rdy_q     <= 1'b0;
            vld_q     <= 1'b0;
            head_q    <= '0;
            cnt_q     <= 16'd0;
            len_q     <= 16'd1;
            vec_count <= 32'd0;
        end else if (clear) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rdy_q     <= 1'b1;
            vld_q     <= 1'b0;
            head_q    <= '0;
            cnt_q     <= 16'd0;
            len_q     <= 16'd1;
            vec_count <= 32'd0;
        end else begin
            wptr_q <= wptr_n;
            rptr_q <= rptr_n;
            rdy_q  <= (occ_n != PW'(DEPTH));
            vld_q  <= (wptr_n != rptr_n);
            if (head_load && (wptr_n != rptr_n)) begin
                head_q <= head_n;
            end
            if (push) begin
                if (cnt_q == 16'd0) begin
                    len_q <= cur_len;
                end
                cnt_q <= in_last ? 16'd0 : cnt_q + 16'd1;
            end
            if (pop && head_q[DOUT_W]) begin
                vec_count <= vec_count + 32'd1;
            end
        end
    end

endmodule
